sar_conv_sequencer: RTL and testbench
=====================================

# sar_conv_sequencer

Finite-state controller that sequences one successive-approximation conversion and the optional tracking phase that follows it. It drives the trial word and the 2-bit phase code into the SAR timer/register block, and it samples the comparator once per settled trial. It then publishes the resolved code together with Inc/Dcr tracking pulses. It sits between the host control interface and the SAR timer/DAC datapath.

## Interface
- NBITS, 8, trial/result word width
- SAMPLE_CYC, 4, cycles spent in SAMPLE phase (≥1)
- SETTLE_W, 6, width of SettleCfg / settle counter
- ClockT  in  1  system clock, all state on rising edge
- ResetN  in  1  asynchronous, active-low reset
- Start  in  1  begin conversion; sampled only in IDLE
- Abort  in  1  force return to IDLE; priority over everything except ResetN
- TrackEn  in  1  enter/remain in TRACK after conversion
- SettleCfg  in  SETTLE_W  settle cycles per trial; 0 treated as 1; latched on accepted Start
- CompIn  in  1  comparator: 1 = analog ≥ DAC(SAROut)
- StateP  out  2  phase code: 00 IDLE, 01 SAMPLE, 10 CONVERT, 11 TRACK
- SAROut  out  NBITS  trial word to DAC / SAR timer
- DataOut  out  NBITS  last resolved/tracked code
- SampleEn  out  1  high while StateP==01
- Busy  out  1  high in SAMPLE and CONVERT
- Done  out  1  one-cycle pulse when conversion resolves
- Inc  out  1  one-cycle pulse, tracking step up
- Dcr  out  1  one-cycle pulse, tracking step down

## Operation
- Reset (ResetN low, async): StateP=00, SAROut=0, DataOut=0, SampleEn=Busy=Done=Inc=Dcr=0, counters 0.
- S = max(SettleCfg_latched, 1).
- IDLE:
  - Start=1 → SAMPLE; SettleCfg latched.
  - SAROut holds its value.
  - Start in any other state is ignored.
- SAMPLE:
  - Lasts exactly SAMPLE_CYC cycles.
  - On exit: SAROut=1000_0000, bit index=NBITS-1, settle count=S-1 → CONVERT.
- CONVERT:
  - Settle counter decrements each cycle.
  - At the edge where count==0, CompIn is sampled. CompIn=0 clears the current bit; CompIn=1 keeps it.
  - At the same edge, if index>0: set bit index-1, decrement index, reload count=S-1.
  - If index==0 at that edge: DataOut ← resolved word, Done=1 for the next cycle; next state TRACK if TrackEn=1, else IDLE.
- TRACK:
  - Every S cycles, at the step edge: CompIn=1 and SAROut≠all-ones → SAROut+1, Inc pulse.
  - At the step edge: CompIn=0 and SAROut≠0 → SAROut-1, Dcr pulse.
  - At saturation: no change, no pulse.
  - DataOut ← new SAROut at each step edge. Done is not pulsed.
  - TrackEn=0 → IDLE at next edge; any partial step is discarded.
- Abort=1 (any non-IDLE state): IDLE at next edge, SAROut=0, DataOut unchanged, no Done/Inc/Dcr. Abort together with Start in IDLE: stay IDLE.
- Inc and Dcr are never high simultaneously. Done and Inc/Dcr are never high in the same cycle.

## Timing
- All outputs are registered; StateP/Busy/SampleEn change on the edge that changes state.
- Done is high in cycle SAMPLE_CYC + NBITS·S after the edge that accepted Start (cycle 0 = first SAMPLE cycle).
- Each trial word is stable for exactly S cycles before its CompIn sample edge.
- Tracking step period: S cycles. The first step edge is S cycles after TRACK entry.
- Back-to-back conversions: Start may be accepted in the first IDLE cycle after Done.
- ResetN asserted mid-operation: all outputs go to reset values immediately (asynchronously). Release is synchronous to the next ClockT edge.

## Test plan
- Comparator model CompIn=(A ≥ SAROut). A=0xA5, SettleCfg=2 → SAROut sequence 80,C0,A0,B0,A8,A4,A6,A5, each held 2 cycles; Done in cycle 20; DataOut=0xA5; Busy low after.
- SettleCfg=0, A=0x00 then A=0xFF → each conversion takes 4+8=12 cycles; DataOut=0x00 then 0xFF.
- A=0xFD, TrackEn=1, SettleCfg=3 → Done with 0xFD. A then 0xFF → Inc at 3-cycle steps: SAROut FE, FF; then no further Inc. A then 0x00 → Dcr pulses down to 00; then no further Dcr.
- Abort asserted while index=3 → StateP=00 next cycle, SAROut=0, DataOut keeps prior value, no Done. Start pulsed during CONVERT → no effect.
- ResetN low mid-CONVERT → all outputs zero immediately. After release, Start with A=0x3C → DataOut=0x3C with normal latency.

Source files
------------

// File: rtl/sar_conv_sequencer.sv
// Sequencer for one SAR conversion (sample, bit-by-bit trials) followed by optional
// comparator-driven tracking. All outputs come straight from flops.
module sar_conv_sequencer #(
  parameter int NBITS      = 8,
  parameter int SAMPLE_CYC = 4,
  parameter int SETTLE_W   = 6
) (
  input  logic                ClockT,
  input  logic                ResetN,
  input  logic                Start,
  input  logic                Abort,
  input  logic                TrackEn,
  input  logic [SETTLE_W-1:0] SettleCfg,
  input  logic                CompIn,
  output logic [1:0]          StateP,
  output logic [NBITS-1:0]    SAROut,
  output logic [NBITS-1:0]    DataOut,
  output logic                SampleEn,
  output logic                Busy,
  output logic                Done,
  output logic                Inc,
  output logic                Dcr
);

  // state   | meaning
  // IDLE    | waiting for Start, SAROut held
  // SAMPLE  | input sampling, SAMPLE_CYC cycles
  // CONVERT | one trial bit per S cycles, MSB first
  // TRACK   | +/-1 step of the code every S cycles
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SAMPLE  = 2'b01,
    CONVERT = 2'b10,
    TRACK   = 2'b11
  } state_t;

  localparam int IW  = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int SCW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

  state_t              state, state_n;
  logic [NBITS-1:0]    sar_n, data_n, trial;
  logic [SETTLE_W-1:0] s_m1, s_m1_n, cnt, cnt_n;
  logic [IW-1:0]       idx, idx_n;
  logic [SCW-1:0]      scnt, scnt_n;
  logic                done_n, inc_n, dcr_n;

  assign StateP = state;

  always_ff @(posedge ClockT or negedge ResetN) begin
    if (!ResetN) begin
      state    <= IDLE;
      SAROut   <= '0;
      DataOut  <= '0;
      s_m1     <= '0;
      cnt      <= '0;
      idx      <= '0;
      scnt     <= '0;
      Done     <= 1'b0;
      Inc      <= 1'b0;
      Dcr      <= 1'b0;
      Busy     <= 1'b0;
      SampleEn <= 1'b0;
    end else begin
      state    <= state_n;
      SAROut   <= sar_n;
      DataOut  <= data_n;
      s_m1     <= s_m1_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      scnt     <= scnt_n;
      Done     <= done_n;
      Inc      <= inc_n;
      Dcr      <= dcr_n;
      Busy     <= (state_n == SAMPLE) || (state_n == CONVERT);
      SampleEn <= (state_n == SAMPLE);
    end
  end

  always_comb begin
    state_n = state;
    sar_n   = SAROut;
    data_n  = DataOut;
    s_m1_n  = s_m1;
    cnt_n   = cnt;
    idx_n   = idx;
    scnt_n  = scnt;
    done_n  = 1'b0;
    inc_n   = 1'b0;
    dcr_n   = 1'b0;
    trial   = SAROut;

    case (state)
      IDLE: begin
        if (Start && !Abort) begin
          state_n = SAMPLE;
          // the settle period is kept as S-1 so a zero setting behaves like one cycle
          s_m1_n  = (SettleCfg == '0) ? '0 : SettleCfg - SETTLE_W'(1);
          scnt_n  = SCW'(SAMPLE_CYC - 1);
        end
      end

      SAMPLE: begin
        if (scnt == '0) begin
          state_n = CONVERT;
          sar_n   = {1'b1, {(NBITS-1){1'b0}}};
          idx_n   = IW'(NBITS - 1);
          cnt_n   = s_m1;
        end else begin
          scnt_n = scnt - SCW'(1);
        end
      end

      CONVERT: begin
        if (cnt == '0) begin
          trial[idx] = CompIn;
          cnt_n      = s_m1;
          if (idx != '0) begin
            trial[idx - IW'(1)] = 1'b1;
            idx_n               = idx - IW'(1);
            sar_n               = trial;
          end else begin
            sar_n   = trial;
            data_n  = trial;
            done_n  = 1'b1;
            state_n = TrackEn ? TRACK : IDLE;
          end
        end else begin
          cnt_n = cnt - SETTLE_W'(1);
        end
      end

      TRACK: begin
        if (!TrackEn) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          cnt_n = s_m1;
          if (CompIn && !(&SAROut)) begin
            sar_n = SAROut + NBITS'(1);
            inc_n = 1'b1;
          end else if (!CompIn && (SAROut != '0)) begin
            sar_n = SAROut - NBITS'(1);
            dcr_n = 1'b1;
          end
          data_n = sar_n;
        end else begin
          cnt_n = cnt - SETTLE_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase

    // abort wins over every in-flight action but leaves the last published code alone
    if (Abort && (state != IDLE)) begin
      state_n = IDLE;
      sar_n   = '0;
      data_n  = DataOut;
      cnt_n   = '0;
      done_n  = 1'b0;
      inc_n   = 1'b0;
      dcr_n   = 1'b0;
    end
  end

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Self-checking bench for sar_conv_sequencer: ideal comparator model, table of
// conversions, randomized conversions, and hand sequences for track/abort/reset.
module tb_sar_conv_sequencer;
  localparam int NBITS      = 8;
  localparam int SAMPLE_CYC = 4;
  localparam int SETTLE_W   = 6;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                track_en = 1'b0;
  logic [SETTLE_W-1:0] settle = '0;
  logic                comp_in;
  logic [1:0]          state_p;
  logic [NBITS-1:0]    sar_out, data_out;
  logic                sample_en, busy, done, inc, dcr;

  logic [NBITS-1:0]    ana = '0;
  logic                force_en = 1'b0;
  logic                force_val = 1'b0;
  logic [NBITS-1:0]    m_sar;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    int         cfg;
    int         cycles;
    logic [7:0] exp_data;
  } vec_t;
  vec_t tbl[5];

  // ideal comparator: analog >= DAC(trial), optionally overridden for rail tests
  assign comp_in = force_en ? force_val : (ana >= sar_out);

  always #5 clk = ~clk;

  sar_conv_sequencer #(
    .NBITS(NBITS), .SAMPLE_CYC(SAMPLE_CYC), .SETTLE_W(SETTLE_W)
  ) dut (
    .ClockT(clk), .ResetN(rst_n), .Start(start), .Abort(abort), .TrackEn(track_en),
    .SettleCfg(settle), .CompIn(comp_in), .StateP(state_p), .SAROut(sar_out),
    .DataOut(data_out), .SampleEn(sample_en), .Busy(busy), .Done(done),
    .Inc(inc), .Dcr(dcr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // binary-search trial for bit b: resolved upper bits of a, bit b set, lower bits clear
  function automatic int trial_of(input int a, input int b);
    return (a & (256 - (2 << b))) | (1 << b);
  endfunction

  // Runs one conversion from IDLE; returns at the negedge of the Done cycle
  // (plus one IDLE cycle when not tracking).
  task automatic conv(input logic [7:0] a, input int cfg, input int exp_cycles,
                      input logic [7:0] exp_data, input logic trk);
    int s, c, k, b;
    s = (cfg == 0) ? 1 : cfg;
    ana = a; settle = SETTLE_W'(cfg); track_en = trk; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (c < exp_cycles + 8 && !done) begin
      if (c < SAMPLE_CYC) begin
        chk("sample_state", state_p, 1);
        chk("sample_en", sample_en, 1);
        chk("busy_sample", busy, 1);
      end else begin
        k = (c - SAMPLE_CYC) / s;
        b = NBITS - 1 - k;
        if (b >= 0) begin
          chk("trial", sar_out, trial_of(a, b));
          chk("conv_state", state_p, 2);
        end
      end
      @(negedge clk);
      c++;
    end
    chk("done_cycle", c, exp_cycles);
    chk("data_out", data_out, exp_data);
    chk("done_state", state_p, trk ? 3 : 0);
    chk("busy_at_done", busy, 0);
    if (!trk) begin
      @(negedge clk);
      chk("done_single", done, 0);
      chk("idle_after", state_p, 0);
    end
  endtask

  // Tracking reference: every s cycles step m_sar by +/-1 toward the comparator, saturating.
  task automatic track_steps(input int steps, input int s);
    logic cmp, e_inc, e_dcr;
    for (int i = 0; i < steps; i++) begin
      for (int j = 1; j <= s; j++) begin
        e_inc = 1'b0; e_dcr = 1'b0;
        if (j == s) begin
          cmp = force_en ? force_val : (ana >= m_sar);
          if (cmp && m_sar != 8'hFF) begin m_sar = m_sar + 8'd1; e_inc = 1'b1; end
          else if (!cmp && m_sar != 8'h00) begin m_sar = m_sar - 8'd1; e_dcr = 1'b1; end
        end
        @(negedge clk);
        chk("trk_sar", sar_out, m_sar);
        chk("trk_data", data_out, m_sar);
        chk("trk_inc", inc, e_inc);
        chk("trk_dcr", dcr, e_dcr);
        chk("trk_nodone", done, 0);
      end
    end
  endtask

  initial begin
    int a, cfg, c;
    logic seen;
    tbl[0] = '{8'hA5, 2, 20, 8'hA5};
    tbl[1] = '{8'h00, 0, 12, 8'h00};
    tbl[2] = '{8'hFF, 0, 12, 8'hFF};
    tbl[3] = '{8'h3C, 1, 12, 8'h3C};
    tbl[4] = '{8'h81, 7, 60, 8'h81};

    #1 rst_n = 1'b0;
    #10;
    chk("rst_state", state_p, 0);
    chk("rst_sar", sar_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_flags", {sample_en, busy, done, inc, dcr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      conv(tbl[i].a, tbl[i].cfg, tbl[i].cycles, tbl[i].exp_data, 1'b0);

    for (int i = 0; i < 16; i++) begin
      a = $urandom_range(0, 255);
      cfg = $urandom_range(0, 6);
      conv(8'(a), cfg, SAMPLE_CYC + NBITS * ((cfg == 0) ? 1 : cfg), 8'(a), 1'b0);
    end

    // tracking: climb to full scale, saturate, then fall to zero and saturate
    conv(8'hFD, 3, SAMPLE_CYC + NBITS * 3, 8'hFD, 1'b1);
    m_sar = 8'hFD;
    force_en = 1'b1; force_val = 1'b1;
    track_steps(4, 3);
    chk("sat_high", sar_out, 8'hFF);
    force_val = 1'b0;
    track_steps(257, 3);
    chk("sat_low", sar_out, 8'h00);
    track_en = 1'b0;
    @(negedge clk);
    chk("trk_exit_state", state_p, 0);
    chk("trk_exit_pulses", {inc, dcr, done}, 0);
    force_en = 1'b0;

    // abort at bit index 3, with a stray Start during CONVERT
    conv(8'h77, 1, 12, 8'h77, 1'b0);
    ana = 8'h5A; settle = 6'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (c = 0; c < SAMPLE_CYC + 8; c++) begin
      if (c == SAMPLE_CYC + 4) start = 1'b1;
      if (c == SAMPLE_CYC + 5) start = 1'b0;
      if (c >= SAMPLE_CYC) chk("abort_trial", sar_out, trial_of(8'h5A, 7 - (c - SAMPLE_CYC) / 2));
      @(negedge clk);
    end
    chk("abort_pre_idx3", sar_out, trial_of(8'h5A, 3));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_state", state_p, 0);
    chk("abort_sar", sar_out, 0);
    chk("abort_data", data_out, 8'h77);
    chk("abort_flags", {busy, done, inc, dcr}, 0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done || state_p != 2'd0) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);

    // Start together with Abort in IDLE stays IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", state_p, 0);
    @(negedge clk);
    chk("start_abort_idle2", state_p, 0);

    // asynchronous reset mid-conversion
    ana = 8'hC3; settle = 6'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_conv", state_p, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", state_p, 0);
    chk("arst_sar", sar_out, 0);
    chk("arst_data", data_out, 0);
    chk("arst_flags", {sample_en, busy, done, inc, dcr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    conv(8'h3C, 0, 12, 8'h3C, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
